ddr_local_arbiter: RTL



---
 rtl/ddr_arb_pkg.sv | 20 ++
 rtl/ddr_local_arbiter_if.sv | 51 +++++
 rtl/ddr_arb_tag_fifo.sv | 48 ++++
 rtl/ddr_local_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types for the DDR2 local-interface arbiter: FSM states, read tag
// layout and the port index width.
package ddr_arb_pkg;

  localparam int unsigned ARB_MAX_PORTS  = 8;
  localparam int unsigned ARB_PORT_IDX_W = $clog2(ARB_MAX_PORTS);
  localparam int unsigned ARB_MAX_SIZE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ARB_PORT_IDX_W-1:0] port;
    logic [ARB_MAX_SIZE_W-1:0] size;
  } arb_tag_t;

endpackage

// File: rtl/ddr_local_arbiter_if.sv
// Requester-side and controller-side bus of the DDR local arbiter.
// slave = arbiter view, master = requesters/controller view.
interface ddr_local_arbiter_if #(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 4
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            port_req_i;
  logic [NUM_PORTS-1:0]            port_we_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_address_i;
  logic [NUM_PORTS*SIZE_WIDTH-1:0] port_size_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata_i;
  logic [NUM_PORTS*BE_WIDTH-1:0]   port_be_i;
  logic [NUM_PORTS-1:0]            port_ready_o;
  logic [DATA_WIDTH-1:0]           port_rdata_o;
  logic [NUM_PORTS-1:0]            port_rdata_valid_o;

  logic [ADDR_WIDTH-1:0]           local_address_o;
  logic [SIZE_WIDTH-1:0]           local_size_o;
  logic [DATA_WIDTH-1:0]           local_wdata_o;
  logic [BE_WIDTH-1:0]             local_be_o;
  logic                            local_write_req_o;
  logic                            local_read_req_o;
  logic                            local_burstbegin_o;
  logic                            local_ready_i;
  logic                            local_rdata_valid_i;
  logic [DATA_WIDTH-1:0]           local_rdata_i;
  logic                            err_o;

  modport slave (
    input  port_req_i, port_we_i, port_address_i, port_size_i, port_wdata_i, port_be_i,
    output port_ready_o, port_rdata_o, port_rdata_valid_o,
    output local_address_o, local_size_o, local_wdata_o, local_be_o,
    output local_write_req_o, local_read_req_o, local_burstbegin_o,
    input  local_ready_i, local_rdata_valid_i, local_rdata_i,
    output err_o
  );

  modport master (
    output port_req_i, port_we_i, port_address_i, port_size_i, port_wdata_i, port_be_i,
    input  port_ready_o, port_rdata_o, port_rdata_valid_o,
    input  local_address_o, local_size_o, local_wdata_o, local_be_o,
    input  local_write_req_o, local_read_req_o, local_burstbegin_o,
    output local_ready_i, local_rdata_valid_i, local_rdata_i,
    input  err_o
  );

endinterface

// File: rtl/ddr_arb_tag_fifo.sv
// Outstanding-read tag FIFO: first-word fall-through head, full/empty flags.
// DEPTH must be a power of two.
module ddr_arb_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  arb_tag_t i_tag,
  input  logic     i_pop,
  output arb_tag_t o_head,
  output logic     o_full,
  output logic     o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  arb_tag_t         r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/ddr_local_arbiter.sv
// N-port burst arbiter onto a DDR2 controller local interface, with a read
// tag FIFO steering returned data. Define DDR_ARB_FIXED_PRIO_EN for strict
// lowest-index priority instead of round-robin.
module ddr_local_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_WIDTH = 4,
  parameter int unsigned RD_TAGS    = 8
) (
  input logic               local_clk,
  input logic               local_reset_n,
  ddr_local_arbiter_if.slave bus
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = ARB_PORT_IDX_W;

  arb_state_e              r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_grant;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [SIZE_WIDTH-1:0]   r_size;
  logic [SIZE_WIDTH-1:0]   r_beat, w_beat_nxt, w_beat_inc;
  logic [SIZE_WIDTH-1:0]   r_rbeat, w_rbeat_inc;
  logic                    r_err;

  logic [NUM_PORTS-1:0]    w_elig;
  logic                    w_win_found;
  logic [IDX_W-1:0]        w_win_idx;
  logic                    w_win_we;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic [SIZE_WIDTH-1:0]   w_win_size;
  logic [DATA_WIDTH-1:0]   w_gnt_wdata;
  logic [BE_WIDTH-1:0]     w_gnt_be;

  logic w_latch, w_push, w_accept, w_wr_req, w_rd_req, w_bb;
  logic w_fifo_full, w_fifo_empty, w_ret_hit, w_pop;
  arb_tag_t w_head, w_push_tag;
  logic [NUM_PORTS-1:0] w_port_ready, w_port_rvalid;

  // Reads are not eligible while no tag slot is free.
  assign w_elig = bus.port_req_i & ~(~bus.port_we_i & {NUM_PORTS{w_fifo_full}});

`ifdef DDR_ARB_FIXED_PRIO_EN
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_found = 1'b1;
        w_win_idx   = IDX_W'(i);
      end
    end
  end
`else
  localparam int unsigned IDX1_W = IDX_W + 1;

  logic [IDX_W-1:0]         r_rr_ptr;
  logic [IDX1_W-1:0]        w_rr_idx;
  logic [ARB_MAX_PORTS-1:0] w_elig_ext;

  assign w_elig_ext = ARB_MAX_PORTS'(w_elig);

  // Search starts at r_rr_ptr and wraps modulo NUM_PORTS.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_rr_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_rr_idx = IDX1_W'(r_rr_ptr) + IDX1_W'(i);
      if (w_rr_idx >= IDX1_W'(NUM_PORTS)) w_rr_idx = w_rr_idx - IDX1_W'(NUM_PORTS);
      if (!w_win_found && w_elig_ext[w_rr_idx[IDX_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_rr_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge local_clk or negedge local_reset_n) begin
    if (!local_reset_n) r_rr_ptr <= '0;
    else if (w_latch)   r_rr_ptr <= (w_win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : w_win_idx + IDX_W'(1);
  end
`endif

  // Per-port field select: winner command fields and granted write beat.
  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_size  = '0;
    w_gnt_wdata = '0;
    w_gnt_be    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_win_idx == IDX_W'(p)) begin
        w_win_we   = bus.port_we_i[p];
        w_win_addr = bus.port_address_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_size = bus.port_size_i[p*SIZE_WIDTH +: SIZE_WIDTH];
      end
      if (r_grant == IDX_W'(p)) begin
        w_gnt_wdata = bus.port_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        w_gnt_be    = bus.port_be_i[p*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  assign w_beat_inc = r_beat + SIZE_WIDTH'(1);

  always_ff @(posedge local_clk or negedge local_reset_n) begin
    if (!local_reset_n) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_latch     = 1'b0;
    w_push      = 1'b0;
    w_accept    = 1'b0;
    w_wr_req    = 1'b0;
    w_rd_req    = 1'b0;
    w_bb        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_found) begin
          w_latch     = 1'b1;
          w_beat_nxt  = '0;
          w_state_nxt = w_win_we ? WRITE : READ;
        end
      end
      WRITE: begin
        w_wr_req = 1'b1;
        w_bb     = (r_beat == '0);
        if (bus.local_ready_i) begin
          w_accept = 1'b1;
          if (w_beat_inc == r_size) begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt  = w_beat_inc;
          end
        end
      end
      READ: begin
        w_rd_req = 1'b1;
        w_bb     = 1'b1;
        if (bus.local_ready_i) begin
          w_accept    = 1'b1;
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge local_clk or negedge local_reset_n) begin
    if (!local_reset_n) begin
      r_grant <= '0;
      r_addr  <= '0;
      r_size  <= '0;
      r_beat  <= '0;
      r_rbeat <= '0;
      r_err   <= 1'b0;
    end else begin
      r_beat <= w_beat_nxt;
      if (w_latch) begin
        r_grant <= w_win_idx;
        r_addr  <= w_win_addr;
        r_size  <= (w_win_size == '0) ? SIZE_WIDTH'(1) : w_win_size;
      end
      if (w_pop)          r_rbeat <= '0;
      else if (w_ret_hit) r_rbeat <= w_rbeat_inc;
      if (bus.local_rdata_valid_i && w_fifo_empty) r_err <= 1'b1;
    end
  end

  assign w_push_tag  = {r_grant, ARB_MAX_SIZE_W'(r_size)};
  assign w_rbeat_inc = r_rbeat + SIZE_WIDTH'(1);
  assign w_ret_hit   = bus.local_rdata_valid_i && !w_fifo_empty;
  assign w_pop       = w_ret_hit && (ARB_MAX_SIZE_W'(w_rbeat_inc) == w_head.size);

  ddr_arb_tag_fifo #(.DEPTH(RD_TAGS)) u_tag_fifo (
    .clk     (local_clk),
    .rst_n   (local_reset_n),
    .i_push  (w_push),
    .i_tag   (w_push_tag),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_port_ready  = '0;
    w_port_rvalid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_port_ready[p]  = w_accept && (r_grant == IDX_W'(p));
      w_port_rvalid[p] = w_ret_hit && (w_head.port == IDX_W'(p));
    end
  end

  assign bus.port_ready_o       = w_port_ready;
  assign bus.port_rdata_o       = bus.local_rdata_i;
  assign bus.port_rdata_valid_o = w_port_rvalid;
  assign bus.local_address_o    = r_addr;
  assign bus.local_size_o       = r_size;
  assign bus.local_wdata_o      = w_wr_req ? w_gnt_wdata : '0;
  assign bus.local_be_o         = w_wr_req ? w_gnt_be : '0;
  assign bus.local_write_req_o  = w_wr_req;
  assign bus.local_read_req_o   = w_rd_req;
  assign bus.local_burstbegin_o = w_bb;
  assign bus.err_o              = r_err;

endmodule
